// File: rtl/mpq_host_if.sv
// MPQ stream bus: host-driven data/command strobes plus MPQ status returns.
// master = command-side driver (mpq_host), slave = MPQ block.
interface mpq_host_if;
  logic       data_valid;
  logic [7:0] data;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [7:0] index;
  logic [7:0] value;
  logic       busy;
  logic       RAM_valid;
  logic       done;

  modport master (
    output data_valid, data, cmd_valid, cmd, index, value,
    input  busy, RAM_valid, done
  );

  modport slave (
    input  data_valid, data, cmd_valid, cmd, index, value,
    output busy, RAM_valid, done
  );
endinterface

// File: rtl/mpq_host.sv
// Command-side driver for MPQ: buffers a data burst and a command list, streams them out, then
// waits for done. Optional watchdog is built when MPQ_HOST_WDOG_EN is defined.
module mpq_host #(
  parameter int unsigned DATA_DEPTH  = 16,
  parameter int unsigned CMD_DEPTH   = 16,
  parameter int unsigned WDOG_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load_valid,
  input  logic        load_sel,
  input  logic [7:0]  load_data,
  input  logic [2:0]  load_cmd,
  input  logic [7:0]  load_index,
  input  logic [7:0]  load_value,
  input  logic        start,
  mpq_host_if.master  mpq,
  output logic        running,
  output logic        finished,
  output logic        early,
  output logic        timeout,
  output logic [7:0]  ram_wr_cnt,
  output logic        load_full
);

  localparam int unsigned DCW = $clog2(DATA_DEPTH + 1);
  localparam int unsigned CCW = $clog2(CMD_DEPTH + 1);
  localparam int unsigned DAW = $clog2(DATA_DEPTH);
  localparam int unsigned CAW = $clog2(CMD_DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_CMD  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]     state;
  logic [7:0]     data_mem [DATA_DEPTH];
  logic [18:0]    cmd_mem  [CMD_DEPTH];
  logic [DCW-1:0] d_cnt, d_cnt_nx, d_ptr;
  logic [CCW-1:0] c_cnt, c_cnt_nx, c_ptr;
  logic           guard;
  logic           ctrl_idle, go, stop, wdog_hit;
  logic           d_full, c_full, d_load, c_load, d_last, c_last;
  logic [18:0]    c_word;

  assign ctrl_idle = (state == S_IDLE) || (state == S_DONE);
  assign go        = ctrl_idle && start;
  assign d_full    = (d_cnt == DCW'(DATA_DEPTH));
  assign c_full    = (c_cnt == CCW'(CMD_DEPTH));
  // Fullness follows the live buffer select, so this is a mux of registered flags.
  assign load_full = load_sel ? c_full : d_full;
  assign d_load    = ctrl_idle && load_valid && !clr && !load_sel && !d_full;
  assign c_load    = ctrl_idle && load_valid && !clr &&  load_sel && !c_full;
  assign d_last    = (d_ptr == d_cnt - DCW'(1));
  assign c_last    = (c_ptr == c_cnt - CCW'(1));
  assign c_word    = cmd_mem[c_ptr[CAW-1:0]];
  assign stop      = mpq.done || wdog_hit;

  // Counts after this cycle's clear/load, so a same-cycle start sees the updated lists.
  always_comb begin
    d_cnt_nx = d_cnt;
    c_cnt_nx = c_cnt;
    if (ctrl_idle && clr) begin
      d_cnt_nx = '0;
      c_cnt_nx = '0;
    end else begin
      if (d_load) d_cnt_nx = d_cnt + DCW'(1);
      if (c_load) c_cnt_nx = c_cnt + CCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (d_load) data_mem[d_cnt[DAW-1:0]] <= load_data;
    if (c_load) cmd_mem[c_cnt[CAW-1:0]]  <= {load_cmd, load_index, load_value};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      d_cnt          <= '0;
      c_cnt          <= '0;
      d_ptr          <= '0;
      c_ptr          <= '0;
      guard          <= 1'b0;
      running        <= 1'b0;
      finished       <= 1'b0;
      early          <= 1'b0;
      ram_wr_cnt     <= '0;
      mpq.data_valid <= 1'b0;
      mpq.data       <= '0;
      mpq.cmd_valid  <= 1'b0;
      mpq.cmd        <= '0;
      mpq.index      <= '0;
      mpq.value      <= '0;
    end else begin
      d_cnt          <= d_cnt_nx;
      c_cnt          <= c_cnt_nx;
      guard          <= 1'b0;
      mpq.data_valid <= 1'b0;
      mpq.data       <= '0;
      mpq.cmd_valid  <= 1'b0;
      mpq.cmd        <= '0;
      mpq.index      <= '0;
      mpq.value      <= '0;

      if (running && mpq.RAM_valid && ram_wr_cnt != 8'hFF)
        ram_wr_cnt <= ram_wr_cnt + 8'd1;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            d_ptr      <= '0;
            c_ptr      <= '0;
            ram_wr_cnt <= '0;
            early      <= 1'b0;
            finished   <= 1'b0;
            running    <= 1'b1;
            if (d_cnt_nx != '0)      state <= S_DATA;
            else if (c_cnt_nx != '0) state <= S_CMD;
            else                     state <= S_WAIT;
          end
        end
        S_DATA: begin
          if (stop) begin
            state    <= S_DONE;
            running  <= 1'b0;
            finished <= 1'b1;
            early    <= mpq.done;
          end else begin
            mpq.data_valid <= 1'b1;
            mpq.data       <= data_mem[d_ptr[DAW-1:0]];
            d_ptr          <= d_ptr + DCW'(1);
            if (d_last) state <= (c_cnt != '0) ? S_CMD : S_WAIT;
          end
        end
        S_CMD: begin
          if (stop) begin
            state    <= S_DONE;
            running  <= 1'b0;
            finished <= 1'b1;
            early    <= mpq.done;
          end else if (!mpq.busy && !guard) begin
            // The guard cycle hides MPQ's one-cycle-late busy after each command.
            mpq.cmd_valid <= 1'b1;
            mpq.cmd       <= c_word[18:16];
            mpq.index     <= c_word[15:8];
            mpq.value     <= c_word[7:0];
            guard         <= 1'b1;
            c_ptr         <= c_ptr + CCW'(1);
            if (c_last) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (stop) begin
            state    <= S_DONE;
            running  <= 1'b0;
            finished <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MPQ_HOST_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_cnt;
  logic          timeout_r;

  assign wdog_hit = running && (wdog_cnt == WW'(WDOG_CYCLES - 1));
  assign timeout  = timeout_r;

  always_ff @(posedge clk) begin
    if (rst || go) begin
      wdog_cnt  <= '0;
      timeout_r <= 1'b0;
    end else if (running) begin
      wdog_cnt <= wdog_cnt + WW'(1);
      if (wdog_hit && !mpq.done) timeout_r <= 1'b1;
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_mpq_host.sv
// Directed self-checking bench for mpq_host; watchdog step depends on MPQ_HOST_WDOG_EN.
module tb_mpq_host;
  logic       clk = 1'b0;
  logic       rst, clr, load_valid, load_sel, start;
  logic [7:0] load_data, load_index, load_value;
  logic [2:0] load_cmd;
  logic       running, finished, early, timeout, load_full;
  logic [7:0] ram_wr_cnt;
  int         n_chk = 0;
  int         n_fail = 0;

  mpq_host_if bus ();

  mpq_host #(.DATA_DEPTH(16), .CMD_DEPTH(16), .WDOG_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load_valid(load_valid), .load_sel(load_sel),
    .load_data(load_data), .load_cmd(load_cmd), .load_index(load_index),
    .load_value(load_value), .start(start), .mpq(bus), .running(running),
    .finished(finished), .early(early), .timeout(timeout), .ram_wr_cnt(ram_wr_cnt),
    .load_full(load_full)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish within bound");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_d(input logic [7:0] v);
    load_sel = 1'b0; load_data = v; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic load_c(input int i);
    load_sel = 1'b1; load_cmd = 3'(i); load_index = 8'(i); load_value = 8'(8'h80 + i);
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    bus.done = 1'b1; tick(); bus.done = 1'b0;
    check({tag, "_finished"}, 32'(finished), 32'd1);
    check({tag, "_running"}, 32'(running), 32'd0);
  endtask

  task automatic check_cmd(input int i);
    check("cmd_valid", 32'(bus.cmd_valid), 32'd1);
    check("cmd_word", {13'd0, bus.cmd, bus.index, bus.value},
          {13'd0, 3'(i), 8'(i), 8'(8'h80 + i)});
  endtask

  task automatic check_gap();
    check("gap_valid", 32'(bus.cmd_valid), 32'd0);
    check("gap_word", {13'd0, bus.cmd, bus.index, bus.value}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; load_valid = 1'b0; load_sel = 1'b0; start = 1'b0;
    load_data = '0; load_cmd = '0; load_index = '0; load_value = '0;
    bus.busy = 1'b0; bus.RAM_valid = 1'b0; bus.done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_data_valid", 32'(bus.data_valid), 32'd0);
    check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("rst_flags", {28'd0, running, finished, early, timeout}, 32'd0);
    check("rst_ram_cnt", 32'(ram_wr_cnt), 32'd0);
    check("rst_load_full", 32'(load_full), 32'd0);

    // 12-word data burst, no commands
    for (int i = 0; i < 12; i++) load_d(8'(8'h10 + i));
    do_start();
    check("burst_k_valid", 32'(bus.data_valid), 32'd0);
    check("burst_k_running", 32'(running), 32'd1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("burst_valid", 32'(bus.data_valid), 32'd1);
      check("burst_data", 32'(bus.data), 32'(8'h10 + i));
    end
    tick();
    check("burst_end_valid", 32'(bus.data_valid), 32'd0);
    check("burst_end_data", 32'(bus.data), 32'd0);
    check("burst_wait_running", 32'(running), 32'd1);
    finish_run("burst");
    check("burst_early", 32'(early), 32'd0);

    // 15 commands, busy low: one every second cycle
    do_clr();
    for (int i = 0; i < 15; i++) load_c(i);
    check("cmd15_not_full", 32'(load_full), 32'd0);
    do_start();
    check("cmd_k_valid", 32'(bus.cmd_valid), 32'd0);
    for (int i = 0; i < 15; i++) begin
      tick(); check_cmd(i);
      tick(); check_gap();
    end
    check("cmd_wait_running", 32'(running), 32'd1);
    finish_run("cmd");
    check("cmd_early", 32'(early), 32'd0);

    // busy stall after 3rd command, then done after 5th command
    do_start();
    for (int i = 0; i < 3; i++) begin
      tick(); check_cmd(i);
      if (i < 2) begin tick(); check_gap(); end
    end
    bus.busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(); check("busy_hold", 32'(bus.cmd_valid), 32'd0);
    end
    bus.busy = 1'b0;
    tick(); check_cmd(3);
    tick(); check_gap();
    tick(); check_cmd(4);
    bus.done = 1'b1; tick(); bus.done = 1'b0;
    check("early_flag", 32'(early), 32'd1);
    check("early_finished", 32'(finished), 32'd1);
    check("early_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); check("early_quiet", 32'(bus.cmd_valid), 32'd0);
    end

    // full data buffer, dropped 17th load, RAM_valid saturation, rerun replay
    do_clr();
    for (int i = 0; i < 16; i++) load_d(8'(8'h40 + i));
    check("data_full", 32'(load_full), 32'd1);
    load_d(8'hEE);
    check("data_full_after_drop", 32'(load_full), 32'd1);
    do_start();
    bus.RAM_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("full_data", {23'd0, bus.data_valid, bus.data}, {23'd0, 1'b1, 8'(8'h40 + i)});
    end
    check("ram_cnt_16", 32'(ram_wr_cnt), 32'd16);
    tick();
    check("full_drop_end", 32'(bus.data_valid), 32'd0);
    for (int i = 0; i < 283; i++) tick();
    check("ram_cnt_sat", 32'(ram_wr_cnt), 32'd255);
    bus.RAM_valid = 1'b0;
    finish_run("ram");
    check("ram_cnt_hold", 32'(ram_wr_cnt), 32'd255);
    do_start();
    check("rerun_ram_clr", 32'(ram_wr_cnt), 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("rerun_data", {23'd0, bus.data_valid, bus.data}, {23'd0, 1'b1, 8'(8'h40 + i)});
    end
    tick();
    check("rerun_end", 32'(bus.data_valid), 32'd0);
    finish_run("rerun");

    // load in the same cycle as start is included in the run
    do_clr();
    load_sel = 1'b0; load_data = 8'h5A; load_valid = 1'b1; start = 1'b1;
    tick();
    load_valid = 1'b0; start = 1'b0;
    tick();
    check("same_cycle_data", {23'd0, bus.data_valid, bus.data}, {23'd0, 1'b1, 8'h5A});
    tick();
    check("same_cycle_end", 32'(bus.data_valid), 32'd0);
    finish_run("same_cycle");

    // reset in CMD empties buffers
    do_clr();
    for (int i = 0; i < 3; i++) load_c(i);
    do_start();
    tick(); check_cmd(0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_cmd", {13'd0, bus.cmd_valid, bus.cmd, bus.index, bus.value}, 32'd0);
    check("mid_rst_flags", {28'd0, running, finished, early, timeout}, 32'd0);
    do_start();
    check("post_rst_running", 32'(running), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_idle_bus", {30'd0, bus.data_valid, bus.cmd_valid}, 32'd0);
    end
    finish_run("post_rst");
    check("post_rst_early", 32'(early), 32'd0);

    // watchdog: done never asserted
    do_start();
`ifdef MPQ_HOST_WDOG_EN
    for (int i = 0; i < 49; i++) tick();
    check("wdog_49_timeout", 32'(timeout), 32'd0);
    check("wdog_49_running", 32'(running), 32'd1);
    tick();
    check("wdog_50_timeout", 32'(timeout), 32'd1);
    check("wdog_50_finished", 32'(finished), 32'd1);
    check("wdog_50_early", 32'(early), 32'd0);
`else
    for (int i = 0; i < 60; i++) tick();
    check("nowdog_timeout", 32'(timeout), 32'd0);
    check("nowdog_running", 32'(running), 32'd1);
    finish_run("nowdog");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
